// File: rtl/uart_word_framer.sv
// uart_word_framer: byte/word bridge between the UART byte engines and
// word-level logic. The RX path synchronises the receiver's ready flag and
// assembles WORD_BYTES bytes into one word, published atomically. An
// inter-byte timeout discards stale partial words. The TX path serialises
// a latched word into bytes using the sender's send/sending handshake.
module uart_word_framer #(
   parameter int WORD_BYTES     = 2,
   parameter bit LSB_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   // receive side
   input  logic [7:0]              rx_data,
   input  logic                    rx_ready,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_valid,
   output logic [3:0]              byte_count,
   output logic                    timeout_flag,
   // transmit side
   input  logic [8*WORD_BYTES-1:0] tx_word,
   input  logic                    tx_start,
   output logic                    tx_busy,
   output logic [7:0]              tx_data,
   output logic                    tx_send,
   input  logic                    tx_sending,
   output logic                    tx_done
);

   localparam int         W          = 8 * WORD_BYTES;
   localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0] LAST_SLOT  = 4'(WORD_BYTES - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   // Wire order slot -> byte lane inside the word.
   function automatic int slot_pos(input logic [3:0] slot);
      return LSB_FIRST ? int'(slot) : (WORD_BYTES - 1 - int'(slot));
   endfunction

   // Byte lane that goes out on the wire in the given slot.
   function automatic logic [7:0] pick_byte(input logic [W-1:0] w, input logic [3:0] slot);
      return w[slot_pos(slot)*8 +: 8];
   endfunction

   // ------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------
   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   logic          rx_edge;
   logic [W-1:0]  shadow;
   logic [W-1:0]  word_next;
   logic [TW-1:0] timer;

   // Two-flop synchroniser for rx_ready plus a delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b0;
         rx_sync <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of its source; blocking here would
         // collapse the synchroniser chain into a single stage.
         rx_meta <= rx_ready;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // A held-high rx_ready produces exactly one edge, hence one byte.
   assign rx_edge = rx_sync & ~rx_prev;

   // Shadow word with the incoming byte dropped into its slot.
   always_comb begin
      // NOTE: full default first so no path leaves word_next unassigned,
      // which would otherwise infer a latch.
      word_next = shadow;
      word_next[slot_pos(byte_count)*8 +: 8] = rx_data;
   end

   // Word assembly, atomic publication and inter-byte timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow word is reset along with the control state so a
         // discarded partial word can never leak into a later publication.
         shadow       <= '0;
         word_out     <= '0;
         word_valid   <= 1'b0;
         byte_count   <= 4'd0;
         timeout_flag <= 1'b0;
         timer        <= '0;
      end else begin
         word_valid   <= 1'b0;
         timeout_flag <= 1'b0;
         if (rx_edge) begin
            // A byte always wins over a coinciding timer expiry.
            timer <= '0;
            if (byte_count == LAST_SLOT) begin
               word_out   <= word_next;
               word_valid <= 1'b1;
               byte_count <= 4'd0;
               shadow     <= '0;
            end else begin
               shadow     <= word_next;
               byte_count <= byte_count + 4'd1;
            end
         end else if (byte_count != 4'd0) begin
            if (timer == TIMER_LAST) begin
               byte_count   <= 4'd0;
               shadow       <= '0;
               timer        <= '0;
               timeout_flag <= 1'b1;
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_REQ  = 2'd1,
      TX_WAIT = 2'd2
   } tx_state_t;

   tx_state_t    tx_state;
   logic [W-1:0] tx_latch;
   logic [3:0]   tx_idx;
   logic         send_meta;
   logic         send_sync;

   // Two-flop synchroniser for the sender's busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         send_meta <= 1'b0;
         send_sync <= 1'b0;
      end else begin
         send_meta <= tx_sending;
         send_sync <= send_meta;
      end
   end

   // Byte serialiser: request a byte, wait for the sender to take it and finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_latch <= '0;
         tx_idx   <= 4'd0;
         tx_busy  <= 1'b0;
         tx_data  <= 8'd0;
         tx_send  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (tx_start) begin
                  tx_latch <= tx_word;
                  tx_idx   <= 4'd0;
                  tx_busy  <= 1'b1;
                  tx_data  <= pick_byte(tx_word, 4'd0);
                  tx_send  <= 1'b1;
                  tx_state <= TX_REQ;
               end
            end
            TX_REQ: begin
               if (send_sync) begin
                  tx_send  <= 1'b0;
                  tx_state <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (!send_sync) begin
                  if (tx_idx == LAST_SLOT) begin
                     tx_done  <= 1'b1;
                     tx_busy  <= 1'b0;
                     tx_state <= TX_IDLE;
                  end else begin
                     tx_idx   <= tx_idx + 4'd1;
                     tx_data  <= pick_byte(tx_latch, tx_idx + 4'd1);
                     tx_send  <= 1'b1;
                     tx_state <= TX_REQ;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_word_framer.sv
// Directed testbench for uart_word_framer. Instance a: 2-byte words,
// LSB first, 100-cycle timeout. Instance b: 4-byte words, MSB first.
// Stimulus changes 1 time unit after a rising edge and outputs are sampled
// at that same point, away from the active edge.
module tb_uart_word_framer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance a
   logic [7:0]  rx_data_a = 8'd0;
   logic        rx_ready_a = 1'b0;
   logic [15:0] word_out_a;
   logic        word_valid_a;
   logic [3:0]  byte_count_a;
   logic        timeout_flag_a;
   logic [15:0] tx_word_a = 16'd0;
   logic        tx_start_a = 1'b0;
   logic        tx_busy_a;
   logic [7:0]  tx_data_a;
   logic        tx_send_a;
   logic        tx_sending_a = 1'b0;
   logic        tx_done_a;

   // instance b
   logic [7:0]  rx_data_b = 8'd0;
   logic        rx_ready_b = 1'b0;
   logic [31:0] word_out_b;
   logic        word_valid_b;
   logic [3:0]  byte_count_b;
   logic        timeout_flag_b;
   logic        tx_busy_b;
   logic [7:0]  tx_data_b;
   logic        tx_send_b;
   logic        tx_done_b;

   uart_word_framer #(.WORD_BYTES(2), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(100)) dut_a (
      .clk(clk), .rst(rst),
      .rx_data(rx_data_a), .rx_ready(rx_ready_a), .word_out(word_out_a),
      .word_valid(word_valid_a), .byte_count(byte_count_a), .timeout_flag(timeout_flag_a),
      .tx_word(tx_word_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a), .tx_data(tx_data_a),
      .tx_send(tx_send_a), .tx_sending(tx_sending_a), .tx_done(tx_done_a)
   );

   uart_word_framer #(.WORD_BYTES(4), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(100)) dut_b (
      .clk(clk), .rst(rst),
      .rx_data(rx_data_b), .rx_ready(rx_ready_b), .word_out(word_out_b),
      .word_valid(word_valid_b), .byte_count(byte_count_b), .timeout_flag(timeout_flag_b),
      .tx_word(32'd0), .tx_start(1'b0), .tx_busy(tx_busy_b), .tx_data(tx_data_b),
      .tx_send(tx_send_b), .tx_sending(1'b0), .tx_done(tx_done_b)
   );

   int checks = 0;
   int passed = 0;

   // Event counters sampled on the falling edge.
   int valid_pulses_a = 0;
   int done_pulses_a  = 0;
   int send_rises_a   = 0;
   logic [7:0] sent_a [0:15];
   logic prev_send_a = 1'b0;

   always @(negedge clk) begin
      if (word_valid_a) valid_pulses_a++;
      if (tx_done_a) done_pulses_a++;
      if (tx_send_a && !prev_send_a) begin
         if (send_rises_a < 16) sent_a[send_rises_a] = tx_data_a;
         send_rises_a++;
      end
      prev_send_a = tx_send_a;
   end

   // Sender model: raise tx_sending 2 cycles after tx_send, hold it 20 cycles.
   logic model_en = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (model_en && tx_send_a && !tx_sending_a) begin
            repeat (2) @(posedge clk);
            #1 tx_sending_a = 1'b1;
            repeat (20) @(posedge clk);
            #1 tx_sending_a = 1'b0;
         end
      end
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic rx_byte_a(input logic [7:0] b);
      rx_data_a  = b;
      rx_ready_a = 1'b1;
      repeat (5) @(posedge clk);
      #1 rx_ready_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic rx_byte_b(input logic [7:0] b);
      rx_data_b  = b;
      rx_ready_b = 1'b1;
      repeat (5) @(posedge clk);
      #1 rx_ready_b = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({word_out_a, word_valid_a, byte_count_a, timeout_flag_a, tx_busy_a, tx_data_a, tx_send_a, tx_done_a} !== 33'd0)
         $display("FAIL reset_a: outputs=%h expected 0", {word_out_a, word_valid_a, byte_count_a, timeout_flag_a, tx_busy_a, tx_data_a, tx_send_a, tx_done_a});
      else passed++;
      checks++;
      if ({word_out_b, word_valid_b, byte_count_b, timeout_flag_b, tx_busy_b, tx_data_b, tx_send_b, tx_done_b} !== 49'd0)
         $display("FAIL reset_b: outputs=%h expected 0", {word_out_b, word_valid_b, byte_count_b, timeout_flag_b, tx_busy_b, tx_data_b, tx_send_b, tx_done_b});
      else passed++;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_word_lsb;
      int v0;
      v0 = valid_pulses_a;
      rx_byte_a(8'h34);
      checks++;
      if (byte_count_a !== 4'd1) $display("FAIL lsb_count1: got %0d expected 1", byte_count_a);
      else passed++;
      checks++;
      if (word_out_a !== 16'h0000) $display("FAIL lsb_partial_hidden: got %h expected 0000", word_out_a);
      else passed++;
      // Second byte with an explicit latency check: valid after the 3rd edge.
      rx_data_a  = 8'h12;
      rx_ready_a = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (word_valid_a !== 1'b0) $display("FAIL lsb_early_valid: got %b expected 0", word_valid_a);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (word_valid_a !== 1'b1 || word_out_a !== 16'h1234)
         $display("FAIL lsb_latency: valid=%b word=%h expected 1/1234", word_valid_a, word_out_a);
      else passed++;
      repeat (3) @(posedge clk);
      #1 rx_ready_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (valid_pulses_a - v0 !== 1) $display("FAIL lsb_one_pulse: got %0d pulses expected 1", valid_pulses_a - v0);
      else passed++;
      checks++;
      if (byte_count_a !== 4'd0 || word_out_a !== 16'h1234)
         $display("FAIL lsb_final: count=%0d word=%h expected 0/1234", byte_count_a, word_out_a);
      else passed++;
   endtask

   task automatic test_word_msb;
      logic [7:0] bytes [0:3];
      bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
      for (int i = 0; i < 3; i++) begin
         rx_byte_b(bytes[i]);
         checks++;
         if (byte_count_b !== 4'(i + 1) || word_out_b !== 32'd0)
            $display("FAIL msb_partial%0d: count=%0d word=%h expected %0d/00000000", i, byte_count_b, word_out_b, i + 1);
         else passed++;
      end
      rx_byte_b(bytes[3]);
      checks++;
      if (word_out_b !== 32'hDEADBEEF || byte_count_b !== 4'd0)
         $display("FAIL msb_word: word=%h count=%0d expected deadbeef/0", word_out_b, byte_count_b);
      else passed++;
   endtask

   task automatic test_timeout;
      int n;
      rx_data_a  = 8'hAA;
      rx_ready_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (byte_count_a !== 4'd1) $display("FAIL to_capture: count=%0d expected 1", byte_count_a);
      else passed++;
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) rx_ready_a = 1'b0;
         if (timeout_flag_a) begin
            n = k;
            break;
         end
      end
      checks++;
      if (n !== 100) $display("FAIL to_delay: flag after %0d cycles expected 100", n);
      else passed++;
      checks++;
      if (byte_count_a !== 4'd0 || word_out_a !== 16'h1234)
         $display("FAIL to_discard: count=%0d word=%h expected 0/1234", byte_count_a, word_out_a);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (timeout_flag_a !== 1'b0) $display("FAIL to_pulse_width: flag=%b expected 0", timeout_flag_a);
      else passed++;
      repeat (48) @(posedge clk);
      #1;
      rx_byte_a(8'h11);
      rx_byte_a(8'h22);
      checks++;
      if (word_out_a !== 16'h2211) $display("FAIL to_resync: word=%h expected 2211", word_out_a);
      else passed++;
   endtask

   task automatic test_held_ready;
      rx_data_a  = 8'h55;
      rx_ready_a = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (byte_count_a !== 4'd1 || word_out_a !== 16'h2211)
         $display("FAIL held_once: count=%0d word=%h expected 1/2211", byte_count_a, word_out_a);
      else passed++;
      rx_ready_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx_byte_a(8'h55);
      checks++;
      if (word_out_a !== 16'h5555 || byte_count_a !== 4'd0)
         $display("FAIL held_second: word=%h count=%0d expected 5555/0", word_out_a, byte_count_a);
      else passed++;
   endtask

   task automatic test_tx;
      int s0, d0, k;
      bit busy_gap, done_seen;
      s0 = send_rises_a;
      d0 = done_pulses_a;
      model_en  = 1'b1;
      tx_word_a  = 16'hBEEF;
      tx_start_a = 1'b1;
      @(posedge clk);
      #1 tx_start_a = 1'b0;
      checks++;
      if (tx_busy_a !== 1'b1 || tx_send_a !== 1'b1 || tx_data_a !== 8'hEF)
         $display("FAIL tx_accept: busy=%b send=%b data=%h expected 1/1/ef", tx_busy_a, tx_send_a, tx_data_a);
      else passed++;
      tx_word_a = 16'h1111;
      busy_gap  = 1'b0;
      done_seen = 1'b0;
      for (k = 1; k <= 500; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) tx_start_a = 1'b1;
         if (k == 11) tx_start_a = 1'b0;
         if (tx_done_a) begin
            done_seen = 1'b1;
            break;
         end
         if (!tx_busy_a) busy_gap = 1'b1;
      end
      tx_start_a = 1'b0;
      checks++;
      if (!done_seen) $display("FAIL tx_done_timeout: no tx_done within 500 cycles");
      else passed++;
      checks++;
      if (busy_gap || tx_busy_a !== 1'b0)
         $display("FAIL tx_busy_span: gap=%b busy_at_done=%b expected 0/0", busy_gap, tx_busy_a);
      else passed++;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (send_rises_a - s0 !== 2) $display("FAIL tx_send_count: got %0d expected 2", send_rises_a - s0);
      else passed++;
      checks++;
      if (sent_a[s0] !== 8'hEF || sent_a[s0 + 1] !== 8'hBE)
         $display("FAIL tx_bytes: got %h %h expected ef be", sent_a[s0], sent_a[s0 + 1]);
      else passed++;
      checks++;
      if (done_pulses_a - d0 !== 1 || tx_busy_a !== 1'b0)
         $display("FAIL tx_done_once: pulses=%0d busy=%b expected 1/0", done_pulses_a - d0, tx_busy_a);
      else passed++;
      model_en = 1'b0;
      repeat (25) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      rx_byte_a(8'h77);
      checks++;
      if (byte_count_a !== 4'd1) $display("FAIL rm_partial: count=%0d expected 1", byte_count_a);
      else passed++;
      tx_sending_a = 1'b0;
      tx_word_a    = 16'hA5C3;
      tx_start_a   = 1'b1;
      @(posedge clk);
      #1 tx_start_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tx_send_a !== 1'b1 || tx_data_a !== 8'hC3)
         $display("FAIL rm_tx_pending: send=%b data=%h expected 1/c3", tx_send_a, tx_data_a);
      else passed++;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({word_out_a, word_valid_a, byte_count_a, timeout_flag_a, tx_busy_a, tx_data_a, tx_send_a, tx_done_a} !== 33'd0)
         $display("FAIL rm_outputs: outputs=%h expected 0", {word_out_a, word_valid_a, byte_count_a, timeout_flag_a, tx_busy_a, tx_data_a, tx_send_a, tx_done_a});
      else passed++;
      rx_byte_a(8'h01);
      rx_byte_a(8'h02);
      checks++;
      if (word_out_a !== 16'h0201 || byte_count_a !== 4'd0)
         $display("FAIL rm_rx_after: word=%h count=%0d expected 0201/0", word_out_a, byte_count_a);
      else passed++;
      tx_word_a  = 16'h0102;
      tx_start_a = 1'b1;
      @(posedge clk);
      #1 tx_start_a = 1'b0;
      checks++;
      if (tx_busy_a !== 1'b1 || tx_send_a !== 1'b1 || tx_data_a !== 8'h02)
         $display("FAIL rm_tx_after: busy=%b send=%b data=%h expected 1/1/02", tx_busy_a, tx_send_a, tx_data_a);
      else passed++;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_word_lsb();
      test_word_msb();
      test_timeout();
      test_held_ready();
      test_tx();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
      $fatal(1);
   end

endmodule
